// File: rtl/stream_dispatcher_pkg.sv
// stream_dispatcher_pkg
//   Shared defaults for the stream dispatcher slice and a helper that sizes
//   lane index fields. Imported by the interface, rr_select and the top.
package stream_dispatcher_pkg;

  localparam int REQ_WIDTH_DEF = 4;
  localparam int DW_DEF        = 8;
  localparam int CW_DEF        = 16;

  // Width of an index that addresses n lanes; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_dispatcher_if.sv
// stream_dispatcher_if
//   Groups the upstream (single stream) and downstream (per-lane) handshake
//   signals of the dispatcher.
//   slave  : dispatcher side  (consumes valid_in/data_in/ready_in)
//   master : environment side (drives valid_in/data_in/ready_in)
//   valid_in  - upstream beat valid
//   data_in   - upstream payload, DW bits
//   ready_out - upstream may transfer this cycle
//   valid_out - one-hot-or-zero lane valids
//   data_out  - payload replicated per lane, lane i at [i*DW +: DW]
//   ready_in  - per-lane consumer accept
interface stream_dispatcher_if
  import stream_dispatcher_pkg::*;
#(
  parameter int REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int DW        = DW_DEF
);

  logic                    valid_in;
  logic [DW-1:0]           data_in;
  logic                    ready_out;
  logic [REQ_WIDTH-1:0]    valid_out;
  logic [REQ_WIDTH*DW-1:0] data_out;
  logic [REQ_WIDTH-1:0]    ready_in;

  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_in,
    output ready_out,
    output valid_out,
    output data_out
  );

  modport master (
    output valid_in,
    output data_in,
    output ready_in,
    input  ready_out,
    input  valid_out,
    input  data_out
  );

endinterface

// File: rtl/stream_dispatcher_rr_select.sv
// rr_select
//   Combinational round-robin picker: returns the first set bit of req found
//   when scanning from start upward, wrapping modulo REQ_WIDTH. Reusable for
//   arbiter grant logic.
//   req     - request vector, REQ_WIDTH bits
//   start   - lane where the scan begins
//   idx     - selected lane (equals start when nothing is requested)
//   any_hit - at least one request bit is set
module rr_select
  import stream_dispatcher_pkg::*;
#(
  parameter int REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int IW        = idx_w(REQ_WIDTH)
) (
  input  logic [REQ_WIDTH-1:0] req,
  input  logic [IW-1:0]        start,
  output logic [IW-1:0]        idx,
  output logic                 any_hit
);

  always_comb begin
    idx     = start;
    any_hit = 1'b0;
    for (int k = 0; k < REQ_WIDTH; k++) begin
      int lane;
      lane = (int'(start) + k) % REQ_WIDTH;
      if (!any_hit && req[lane]) begin
        idx     = IW'(lane);
        any_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_dispatcher.sv
// stream_dispatcher
//   Fans a single valid/ready stream out to REQ_WIDTH consumer lanes. Each
//   beat goes to exactly one lane, chosen round-robin among the lanes that
//   are ready when the beat is accepted. One registered holding stage gives
//   one cycle of latency with full throughput.
//   clk     - clock, rising edge
//   rst     - synchronous reset, active low
//   bus     - stream_dispatcher_if.slave (upstream + per-lane handshakes)
//   cnt_out - per-lane delivered-beat counters, lane i at [i*CW +: CW]
//             (present only when STREAM_DISPATCHER_CNT_EN is defined)
// Optional feature macro: STREAM_DISPATCHER_CNT_EN
module stream_dispatcher
  import stream_dispatcher_pkg::*;
#(
  parameter int REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int DW        = DW_DEF
`ifdef STREAM_DISPATCHER_CNT_EN
  , parameter int CW      = CW_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  stream_dispatcher_if.slave bus
`ifdef STREAM_DISPATCHER_CNT_EN
  , output logic [REQ_WIDTH*CW-1:0] cnt_out
`endif
);

  localparam int IW = idx_w(REQ_WIDTH);

  logic          hold_valid;
  logic [DW-1:0] hold_data;
  logic [IW-1:0] hold_sel;
  logic [IW-1:0] ptr;

  logic          out_fire;
  logic          accept;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_hit;
  logic [IW-1:0] pick_sel;

  // ---- stage 0: handshake decode and lane pick (combinational) ----
  always_comb begin
    out_fire = hold_valid && bus.ready_in[hold_sel];
    // When the held beat leaves this cycle, the new beat's scan must already
    // start past the lane just served.
    next_ptr = ptr;
    if (out_fire) begin
      next_ptr = (hold_sel == IW'(REQ_WIDTH - 1)) ? '0 : hold_sel + IW'(1);
    end
    bus.ready_out = !hold_valid || out_fire;
    accept        = bus.valid_in && bus.ready_out;
    // With no ready lane the beat parks on the scan start and waits there.
    pick_sel      = pick_hit ? pick_idx : next_ptr;
  end

  rr_select #(
    .REQ_WIDTH (REQ_WIDTH),
    .IW        (IW)
  ) u_rr_select (
    .req     (bus.ready_in),
    .start   (next_ptr),
    .idx     (pick_idx),
    .any_hit (pick_hit)
  );

  // ---- stage 1: holding register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_sel   <= '0;
      ptr        <= '0;
    end else begin
      if (out_fire) begin
        ptr <= next_ptr;
      end
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= bus.data_in;
        hold_sel   <= pick_sel;
      end else if (out_fire) begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < REQ_WIDTH; i++) begin
      bus.valid_out[i]           = hold_valid && (hold_sel == IW'(i));
      bus.data_out[i*DW +: DW]   = hold_data;
    end
  end

`ifdef STREAM_DISPATCHER_CNT_EN
  logic [CW-1:0] cnt_q [REQ_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (out_fire) begin
      // Natural modulo-2^CW wrap.
      cnt_q[hold_sel] <= cnt_q[hold_sel] + CW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < REQ_WIDTH; i++) begin
      cnt_out[i*CW +: CW] = cnt_q[i];
    end
  end
`endif

endmodule
